// File: rtl/sram_arbiter.sv
// Three-way arbiter for the shared 8-bit external SRAM: video > cpu > loader, with loader anti-starvation.
// Optional build macro SRAM_WPROT_EN: cpu writes below ROM_TOP are timed and acked but never reach the SRAM.
module sram_arbiter #(
    parameter int unsigned AW            = 21,
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter int unsigned STARVE_LIMIT  = 8,
    parameter int unsigned ROM_TOP       = 16384
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vidReq,
    input  logic [AW-1:0] vidA,
    output logic [7:0]    vidQ,
    output logic          vidAck,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic [7:0]    cpuQ,
    output logic          cpuAck,
    input  logic          ldrReq,
    input  logic [AW-1:0] ldrA,
    input  logic [7:0]    ldrD,
    output logic          ldrAck,
    output logic [AW-1:0] sramA,
    inout  logic [7:0]    sramDQ,
    output logic          sramWe
);

    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_LDR} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          drive_q, drive_d;
    logic          we_q, we_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    vidq_q, vidq_d;
    logic [7:0]    cpuq_q, cpuq_d;
    logic          vack_q, vack_d;
    logic          cack_q, cack_d;
    logic          lack_q, lack_d;
    logic          cpu_wp;

`ifdef SRAM_WPROT_EN
    assign cpu_wp = (cpuA < AW'(ROM_TOP));
`else
    logic rom_top_unused;
    assign rom_top_unused = (ROM_TOP != 0);
    assign cpu_wp         = 1'b0;
`endif

    // wr_q marks a write op (no read capture); drive_q marks a write that actually reaches the SRAM
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        drive_d  = drive_q;
        we_d     = we_q;
        starve_d = starve_q;
        vidq_d   = vidq_q;
        cpuq_d   = cpuq_q;
        vack_d   = 1'b0;
        cack_d   = 1'b0;
        lack_d   = 1'b0;

        if (!ldrReq) starve_d = '0;

        case (state_q)
            S_IDLE: begin
                if (vidReq || cpuReq || ldrReq) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    if (vidReq) begin
                        owner_d = OWN_VID;
                        addr_d  = vidA;
                        wr_d    = 1'b0;
                        drive_d = 1'b0;
                    end else if (ldrReq && (starve_q == STARVE_MAX || !cpuReq)) begin
                        owner_d  = OWN_LDR;
                        addr_d   = ldrA;
                        wdata_d  = ldrD;
                        wr_d     = 1'b1;
                        drive_d  = 1'b1;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_CPU;
                        addr_d  = cpuA;
                        wdata_d = cpuD;
                        wr_d    = cpuWe;
                        drive_d = cpuWe && !cpu_wp;
                        if (ldrReq && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RECOVER;
                    we_d    = 1'b1;
                    case (owner_q)
                        OWN_VID: begin
                            vack_d = 1'b1;
                            vidq_d = sramDQ;
                        end
                        OWN_CPU: begin
                            cack_d = 1'b1;
                            if (!wr_q) cpuq_d = sramDQ;
                        end
                        default: lack_d = 1'b1;
                    endcase
                end else begin
                    we_d = !drive_q;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
                drive_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_VID;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            drive_q  <= 1'b0;
            we_q     <= 1'b1;
            starve_q <= '0;
            vidq_q   <= '0;
            cpuq_q   <= '0;
            vack_q   <= 1'b0;
            cack_q   <= 1'b0;
            lack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            drive_q  <= drive_d;
            we_q     <= we_d;
            starve_q <= starve_d;
            vidq_q   <= vidq_d;
            cpuq_q   <= cpuq_d;
            vack_q   <= vack_d;
            cack_q   <= cack_d;
            lack_q   <= lack_d;
        end
    end

    assign sramA  = addr_q;
    assign sramWe = we_q;
    assign sramDQ = drive_q ? wdata_q : 'z;
    assign vidQ   = vidq_q;
    assign cpuQ   = cpuq_q;
    assign vidAck = vack_q;
    assign cpuAck = cack_q;
    assign ldrAck = lack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then random requesters, checked every clock against a slot-level model.
module tb_sram_arbiter;

    localparam int unsigned AW      = 21;
    localparam int unsigned AC      = 3;
    localparam int unsigned SL      = 8;
    localparam int unsigned ROM_TOP = 16384;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vidReq, cpuReq, cpuWe, ldrReq;
    logic [AW-1:0] vidA, cpuA, ldrA;
    logic [7:0]    cpuD, ldrD;
    logic [7:0]    vidQ, cpuQ;
    logic          vidAck, cpuAck, ldrAck;
    logic [AW-1:0] sramA;
    logic          sramWe;
    wire  [7:0]    sramDQ;

    // Bench plays the SRAM: it drives the bus whenever the arbiter should not
    logic          tb_drv;
    logic [7:0]    bus_val;
    assign sramDQ = tb_drv ? bus_val : 8'hzz;

    always #9 clock = ~clock;

    sram_arbiter #(.AW(AW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL), .ROM_TOP(ROM_TOP)) dut (
        .clock(clock), .reset(reset),
        .vidReq(vidReq), .vidA(vidA), .vidQ(vidQ), .vidAck(vidAck),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
        .ldrReq(ldrReq), .ldrA(ldrA), .ldrD(ldrD), .ldrAck(ldrAck),
        .sramA(sramA), .sramDQ(sramDQ), .sramWe(sramWe)
    );

    int unsigned n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef enum {R_VID, R_CPU, R_LDR} who_t;

    int unsigned   cyc = 0;
    bit            m_act;
    int unsigned   m_g;
    who_t          m_own;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;
    bit            m_isw, m_eff;
    int unsigned   m_starve;
    logic [7:0]    m_vidQ, m_cpuQ;
    logic [7:0]    mem [logic [AW-1:0]];

    bit            seen_v, seen_c, seen_l;
    bit            rnd_en = 1'b0, hold_cpu = 1'b0;
    int unsigned   n_vack = 0, n_cack = 0, n_lack = 0, n_we_low = 0;
    int unsigned   last_v = 0, last_c = 0, last_l = 0;

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic bit wprot(input logic [AW-1:0] a);
        bit en;
`ifdef SRAM_WPROT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (a < AW'(ROM_TOP));
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        int unsigned r = $urandom_range(7);
        if (r == 0) return AW'(ROM_TOP - 1);
        if (r == 1) return AW'(ROM_TOP);
        return AW'($urandom_range(31));
    endfunction

    function automatic int unsigned ack_cnt(input int which);
        case (which)
            0:       return n_vack;
            1:       return n_cack;
            default: return n_lack;
        endcase
    endfunction

    task automatic model_reset();
        m_act    = 1'b0;
        m_starve = 0;
        m_vidQ   = 8'h00;
        m_cpuQ   = 8'h00;
        seen_v   = 1'b0;
        seen_c   = 1'b0;
        seen_l   = 1'b0;
    endtask

    task automatic grant(input who_t w, input logic [AW-1:0] a, input logic [7:0] d, input bit isw);
        m_act  = 1'b1;
        m_g    = cyc;
        m_own  = w;
        m_addr = a;
        m_data = d;
        m_isw  = isw;
        m_eff  = isw && !(w == R_CPU && wprot(a));
    endtask

    // One slot = grant edge, ACCESS_CYCLES access clocks, one recover clock, one idle clock
    task automatic model_edge();
        bit was;
        int unsigned k;
        if (!reset) begin
            model_reset();
            return;
        end
        was = m_act;
        if (m_act) begin
            k = cyc - m_g;
            if (k == AC) begin
                if (!m_isw) begin
                    if (m_own == R_VID) m_vidQ = mem_rd(m_addr);
                    else                m_cpuQ = mem_rd(m_addr);
                end else if (m_eff) begin
                    mem[m_addr] = m_data;
                end
            end else if (k == AC + 1) begin
                m_act = 1'b0;
            end
        end
        if (!was) begin
            if (vidReq) begin
                grant(R_VID, vidA, 8'h00, 1'b0);
            end else if (ldrReq && (m_starve == SL || !cpuReq)) begin
                grant(R_LDR, ldrA, ldrD, 1'b1);
                m_starve = 0;
            end else if (cpuReq) begin
                grant(R_CPU, cpuA, cpuD, cpuWe);
                if (ldrReq && m_starve < SL) m_starve++;
            end
        end
        if (!ldrReq) m_starve = 0;
    endtask

    task automatic upd_bus();
        if (m_act && m_eff) begin
            tb_drv = 1'b0;
        end else begin
            tb_drv  = 1'b1;
            bus_val = (m_act && !m_isw) ? mem_rd(m_addr) : (8'(cyc * 37) ^ 8'h96);
        end
    endtask

    task automatic requesters();
        if (seen_v) vidReq = 1'b0;
        if (seen_c && !hold_cpu) cpuReq = 1'b0;
        if (seen_l) ldrReq = 1'b0;
        if (rnd_en) begin
            if (!vidReq && !seen_v && $urandom_range(7) == 0) begin
                vidReq = 1'b1;
                vidA   = rnd_addr();
            end
            if (!cpuReq && !seen_c && $urandom_range(2) == 0) begin
                cpuReq = 1'b1;
                cpuWe  = 1'($urandom_range(1));
                cpuA   = rnd_addr();
                cpuD   = 8'($urandom);
            end
            if (!ldrReq && !seen_l && $urandom_range(5) == 0) begin
                ldrReq = 1'b1;
                ldrA   = rnd_addr();
                ldrD   = 8'($urandom);
            end
            if ($urandom_range(19) == 0) begin
                cpuA = rnd_addr();
                cpuD = 8'($urandom);
                ldrA = rnd_addr();
            end
            if ($urandom_range(29) == 0) vidReq = 1'b0;
        end
    endtask

    task automatic check_cycle();
        int unsigned k;
        bit wlow, av, ac, al;
        k    = cyc - m_g;
        wlow = m_act && m_eff && k >= 1 && k <= AC - 1;
        av   = m_act && k == AC && m_own == R_VID;
        ac   = m_act && k == AC && m_own == R_CPU;
        al   = m_act && k == AC && m_own == R_LDR;
        check("sramWe", sramWe, !wlow);
        check("vidAck", vidAck, av);
        check("cpuAck", cpuAck, ac);
        check("ldrAck", ldrAck, al);
        if (m_act) check("sramA", sramA, m_addr);
        check("sramDQ", sramDQ, (m_act && m_eff) ? m_data : bus_val);
        check("vidQ", vidQ, m_vidQ);
        check("cpuQ", cpuQ, m_cpuQ);
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        requesters();
        upd_bus();
        @(negedge clock);
        check_cycle();
        seen_v = vidAck;
        seen_c = cpuAck;
        seen_l = ldrAck;
        if (vidAck) begin n_vack++; last_v = cyc; end
        if (cpuAck) begin n_cack++; last_c = cyc; end
        if (ldrAck) begin n_lack++; last_l = cyc; end
        if (sramWe === 1'b0) n_we_low++;
    endtask

    task automatic wait_ack(input int which, input int unsigned max_t);
        int unsigned c0 = ack_cnt(which);
        int unsigned t  = 0;
        while (ack_cnt(which) == c0 && t < max_t) begin
            tick();
            t++;
        end
        check("ack_wait_bound", ack_cnt(which) != c0, 1);
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((m_act || vidReq || cpuReq || ldrReq) && t < 60) begin
            tick();
            t++;
        end
        check("drain_bound", t < 60, 1);
    endtask

    initial begin
        int unsigned n0, w0, c0, v0, l0;
        logic [7:0] prot_exp;

        vidReq = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; ldrReq = 1'b0;
        vidA = '0; cpuA = '0; ldrA = '0; cpuD = '0; ldrD = '0;
        tb_drv = 1'b1; bus_val = 8'h5C;
        model_reset();

        // Reset values
        repeat (3) tick();
        check("rst_sramA", sramA, 0);
        reset = 1'b1;
        repeat (2) tick();

        // cpu write 0x4000 <- 0x5A, then read it back
        n0 = cyc + 1; w0 = n_we_low;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuA = 21'h4000; cpuD = 8'h5A;
        wait_ack(1, 20);
        check("wr_ack_latency", last_c - n0, AC);
        drain();
        check("wr_we_low_clocks", n_we_low - w0, 2);
        n0 = cyc + 1;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h4000;
        wait_ack(1, 20);
        check("rd_ack_latency", last_c - n0, AC);
        check("rd_cpuQ", cpuQ, 8'h5A);
        drain();

        // All three requests on the same edge
        n0 = cyc + 1; v0 = n_vack; c0 = n_cack; l0 = n_lack;
        vidReq = 1'b1; vidA = 21'h00100;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h4000;
        ldrReq = 1'b1; ldrA = 21'h00200; ldrD = 8'h77;
        wait_ack(2, 40);
        check("tri_vid_first", last_v - n0, AC);
        check("tri_cpu_gap", last_c - last_v, AC + 2);
        check("tri_ldr_gap", last_l - last_c, AC + 2);
        check("tri_ack_counts", {8'(n_vack - v0), 8'(n_cack - c0), 8'(n_lack - l0)}, 24'h010101);
        drain();

        // Loader starvation guard, twice to show the counter restarts from zero
        hold_cpu = 1'b1;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h4001;
        ldrReq = 1'b1; ldrA = 21'h00300; ldrD = 8'h11;
        c0 = n_cack;
        wait_ack(2, 100);
        check("starve_cpu_acks_1", n_cack - c0, SL);
        tick();
        ldrReq = 1'b1; ldrA = 21'h00301; ldrD = 8'h22;
        c0 = n_cack;
        wait_ack(2, 100);
        check("starve_cpu_acks_2", n_cack - c0, SL);
        hold_cpu = 1'b0;
        drain();

        // Write to the ROM area: dropped only when write protection is built in
`ifdef SRAM_WPROT_EN
        prot_exp = 8'h08;
`else
        prot_exp = 8'hAA;
`endif
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h01234;
        wait_ack(1, 20);
        check("rom_rd_before", cpuQ, 8'h08);
        drain();
        w0 = n_we_low; c0 = n_cack;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuA = 21'h01234; cpuD = 8'hAA;
        wait_ack(1, 20);
        drain();
        check("rom_wr_acked", n_cack - c0, 1);
        check("rom_wr_we_low", n_we_low - w0, (prot_exp == 8'hAA) ? 2 : 0);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h01234;
        wait_ack(1, 20);
        check("rom_rd_after", cpuQ, prot_exp);
        drain();

        // Video request withdrawn mid-access still completes exactly once
        v0 = n_vack;
        vidReq = 1'b1; vidA = 21'h00055;
        tick();
        tick();
        vidReq = 1'b0;
        repeat (12) tick();
        check("vid_drop_acks", n_vack - v0, 1);

        // Reset during the second ACCESS clock of a write
        c0 = n_cack;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuA = 21'h04002; cpuD = 8'h3C;
        tick();
        tick();
        check("pre_rst_we_low", sramWe, 0);
        #2;
        reset = 1'b0;
        cpuReq = 1'b0;
        model_reset();
        tb_drv = 1'b1; bus_val = 8'hE1;
        #1;
        check("midrst_sramWe", sramWe, 1);
        check("midrst_sramDQ", sramDQ, 8'hE1);
        check("midrst_acks", {vidAck, cpuAck, ldrAck}, 0);
        check("midrst_sramA", sramA, 0);
        check("midrst_Q", {vidQ, cpuQ}, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check("midrst_no_ack", n_cack - c0, 0);

        // Random traffic
        rnd_en = 1'b1;
        repeat (2500) tick();
        rnd_en = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
